// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and control field values.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] DST_RD  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU = 3'd0,
    CL_LW  = 3'd1,
    CL_SW  = 3'd2,
    CL_BNE = 3'd3,
    CL_J   = 3'd4,
    CL_JAL = 3'd5,
    CL_JR  = 3'd6
  } iclass_t;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    iclass_t cls;
    ctrl_t   ctrl;
    logic    illegal;
  } dec_t;

  localparam ctrl_t CTRL_NONE = '{alu_src: 1'b0, alu_op: ALU_ADD, reg_dst: DST_RD, mem_to_reg: M2R_ALU};

  function automatic logic [31:0] jump_target(input logic [31:0] seq_pc, input logic [25:0] index);
    return {seq_pc[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: opcode/funct to instruction class, static control fields and illegal flag.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  // Opcode/funct lookup; anything not listed is illegal.
  always_comb begin
    o_dec = '{cls: CL_ALU, ctrl: CTRL_NONE, illegal: 1'b0};
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_dec.ctrl.alu_op = ALU_ADD;
          FN_SUB:  o_dec.ctrl.alu_op = ALU_SUB;
          FN_SLT:  o_dec.ctrl.alu_op = ALU_SLT;
          FN_JR:   o_dec.cls = CL_JR;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_dec.ctrl.alu_src = 1'b1;
        o_dec.ctrl.reg_dst = DST_RT;
      end
      OP_XORI: begin
        o_dec.ctrl.alu_src = 1'b1;
        o_dec.ctrl.alu_op  = ALU_XOR;
        o_dec.ctrl.reg_dst = DST_RT;
      end
      OP_LW: begin
        o_dec.cls             = CL_LW;
        o_dec.ctrl.alu_src    = 1'b1;
        o_dec.ctrl.reg_dst    = DST_RT;
        o_dec.ctrl.mem_to_reg = M2R_MEM;
      end
      OP_SW: begin
        o_dec.cls          = CL_SW;
        o_dec.ctrl.alu_src = 1'b1;
      end
      OP_BNE: begin
        o_dec.cls         = CL_BNE;
        o_dec.ctrl.alu_op = ALU_SUB;
      end
      OP_J:   o_dec.cls = CL_J;
      OP_JAL: begin
        o_dec.cls             = CL_JAL;
        o_dec.ctrl.reg_dst    = DST_R31;
        o_dec.ctrl.mem_to_reg = M2R_PC;
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU sequencer: PC, fetch handshake and FETCH/DECODE/EXEC/MEM/WB control FSM.
// Optional macro INSTR_COUNT_EN adds the retired-instruction counter output instr_count.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] imm,
  output logic [31:0] addedPC,
  output logic [1:0]  RegDst,
  output logic        RegWr,
  output logic        MemWr,
  output logic        ALUSrc,
  output logic [1:0]  MemToReg,
  output logic [2:0]  ALUCntrl,
  input  logic [31:0] Da,
  input  logic        isZero,
  output logic        halted,
  output logic [1:0]  fault
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam int         TMO_LAST_I = FETCH_TIMEOUT - 32'sd1;
  localparam logic [7:0] TMO_LAST   = TMO_LAST_I[7:0];

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_added_pc;
  logic [7:0]  r_tcnt;
  logic [1:0]  r_fault;
  logic        r_halted;
  logic        r_imem_req;
  logic        r_reg_wr;
  logic        r_mem_wr;
  ctrl_t       r_ctrl;

  dec_t        w_dec;
  logic [31:0] w_jump_pc;
  logic [31:0] w_branch_pc;

  instr_decoder u_dec (
    .i_op    (r_ir[31:26]),
    .i_funct (r_ir[5:0]),
    .o_dec   (w_dec)
  );

  assign w_jump_pc   = jump_target(r_added_pc, r_ir[25:0]);
  assign w_branch_pc = r_added_pc + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  // Sequencer: state, PC, IR and every registered control output.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0000_0000;
      r_added_pc <= 32'h0000_0000;
      r_tcnt     <= 8'h00;
      r_fault    <= FLT_NONE;
      r_halted   <= 1'b0;
      r_imem_req <= 1'b1;
      r_reg_wr   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_ctrl     <= CTRL_NONE;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_data;
            r_added_pc <= r_pc + 32'd4;
            r_tcnt     <= 8'h00;
            r_imem_req <= 1'b0;
            r_state    <= DECODE;
          end else if (r_tcnt == TMO_LAST) begin
            r_fault    <= FLT_TIMEOUT;
            r_halted   <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= HALT;
          end else begin
            r_tcnt <= r_tcnt + 8'h01;
          end
        end
        DECODE: begin
          if (w_dec.illegal) begin
            r_fault  <= FLT_ILLEGAL;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else if (w_dec.cls == CL_J) begin
            r_pc       <= w_jump_pc;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end else if (w_dec.cls == CL_JAL) begin
            r_pc     <= w_jump_pc;
            r_ctrl   <= w_dec.ctrl;
            r_reg_wr <= 1'b1;
            r_state  <= WB;
          end else begin
            r_ctrl  <= w_dec.ctrl;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          case (w_dec.cls)
            CL_BNE: begin
              r_pc       <= isZero ? r_added_pc : w_branch_pc;
              r_ctrl     <= CTRL_NONE;
              r_imem_req <= 1'b1;
              r_state    <= FETCH;
            end
            CL_JR: begin
              r_pc       <= Da;
              r_ctrl     <= CTRL_NONE;
              r_imem_req <= 1'b1;
              r_state    <= FETCH;
            end
            CL_LW: r_state <= MEM;
            CL_SW: begin
              r_mem_wr <= 1'b1;
              r_state  <= MEM;
            end
            default: begin
              r_reg_wr <= 1'b1;
              r_state  <= WB;
            end
          endcase
        end
        MEM: begin
          if (w_dec.cls == CL_SW) begin
            r_mem_wr   <= 1'b0;
            r_pc       <= r_added_pc;
            r_ctrl     <= CTRL_NONE;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end else begin
            r_reg_wr <= 1'b1;
            r_state  <= WB;
          end
        end
        WB: begin
          // JAL already loaded its jump target in DECODE
          if (w_dec.cls != CL_JAL) begin
            r_pc <= r_added_pc;
          end
          r_reg_wr   <= 1'b0;
          r_ctrl     <= CTRL_NONE;
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_reg_wr   <= 1'b0;
          r_mem_wr   <= 1'b0;
          r_imem_req <= 1'b0;
          r_halted   <= 1'b1;
          r_state    <= HALT;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] r_instr_count;
  logic        w_retire;

  assign w_retire = ((r_state == DECODE) && (w_dec.cls == CL_J) && !w_dec.illegal) ||
                    ((r_state == EXEC) && ((w_dec.cls == CL_BNE) || (w_dec.cls == CL_JR))) ||
                    ((r_state == MEM) && (w_dec.cls == CL_SW)) ||
                    (r_state == WB);

  // Retired-instruction counter, bumped on each return to FETCH.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_instr_count <= 32'h0000_0000;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 32'h0000_0001;
    end
  end

  assign instr_count = r_instr_count;
`endif

  // Strobes are masked by reset so nothing fires in the cycle reset is raised.
  assign imem_req  = r_imem_req & ~reset;
  assign RegWr     = r_reg_wr & ~reset;
  assign MemWr     = r_mem_wr & ~reset;
  assign imem_addr = r_pc;
  assign Rs        = r_ir[25:21];
  assign Rt        = r_ir[20:16];
  assign Rd        = r_ir[15:11];
  assign imm       = r_ir[15:0];
  assign addedPC   = r_added_pc;
  assign RegDst    = r_ctrl.reg_dst;
  assign ALUSrc    = r_ctrl.alu_src;
  assign MemToReg  = r_ctrl.mem_to_reg;
  assign ALUCntrl  = r_ctrl.alu_op;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule
